// File: rtl/axis_pkt_replay_engine.sv
// AXI-Stream packet replay engine: a flit buffer loaded through a write port and streamed out
// with backpressure, a programmable inter-packet gap, repeat/loop passes and a graceful stop.
module axis_pkt_replay_engine #(
    parameter int unsigned TDATA_WIDTH = 512,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned AW          = $clog2(DEPTH),
    parameter int unsigned GAP_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [TDATA_WIDTH-1:0]   wr_tdata,
    input  logic [TDATA_WIDTH/8-1:0] wr_tkeep,
    input  logic                     wr_tlast,
    input  logic [AW:0]              cfg_num_flits,
    input  logic [15:0]              cfg_repeat,
    input  logic [GAP_W-1:0]         cfg_ipg,
    input  logic                     start,
    input  logic                     stop,
    output logic                     busy,
    output logic                     done,
    output logic [31:0]              pkt_cnt,
    output logic [31:0]              flit_cnt,
    output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready
);
    localparam int unsigned KW = TDATA_WIDTH / 8;

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    // Buffer is deliberately left out of reset so contents survive a reset.
    logic [TDATA_WIDTH-1:0] mem_data [DEPTH];
    logic [KW-1:0]          mem_keep [DEPTH];
    logic                   mem_last [DEPTH];

    state_e                 state_q, state_d;
    logic [AW-1:0]          ptr_q, ptr_d;
    logic [AW:0]            num_q, num_d;
    logic [15:0]            rep_q, rep_d;
    logic [15:0]            pass_q, pass_d;
    logic [GAP_W-1:0]       ipg_q, ipg_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic                   stop_q, stop_d;
    logic                   done_q, done_d;
    logic                   valid_q, valid_d;
    logic [TDATA_WIDTH-1:0] data_q, data_d;
    logic [KW-1:0]          keep_q, keep_d;
    logic                   last_q, last_d;
    logic [31:0]            pkt_q, pkt_d;
    logic [31:0]            flit_q, flit_d;

    logic                   hs;
    logic                   end_pass;
    logic [AW-1:0]          nxt_ptr;
    logic [15:0]            pass_inc;
    logic                   stop_any;

    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign pkt_cnt       = pkt_q;
    assign flit_cnt      = flit_q;
    assign m_axis_tdata  = data_q;
    assign m_axis_tkeep  = keep_q;
    assign m_axis_tlast  = last_q;
    assign m_axis_tvalid = valid_q;

    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            mem_data[wr_addr] <= wr_tdata;
            mem_keep[wr_addr] <= wr_tkeep;
            mem_last[wr_addr] <= wr_tlast;
        end
    end

    assign hs       = valid_q && m_axis_tready;
    assign end_pass = ({1'b0, ptr_q} == (num_q - (AW + 1)'(1)));
    assign nxt_ptr  = end_pass ? '0 : ptr_q + AW'(1);
    assign pass_inc = pass_q + 16'd1;
    // A stop arriving in the same cycle as a boundary takes effect at that boundary.
    assign stop_any = stop_q || stop;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        num_d   = num_q;
        rep_d   = rep_q;
        pass_d  = pass_q;
        ipg_d   = ipg_q;
        gap_d   = gap_q;
        stop_d  = stop_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        pkt_d   = pkt_q;
        flit_d  = flit_q;

        if (busy && stop) begin
            stop_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (cfg_num_flits == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StSend;
                        num_d   = cfg_num_flits;
                        rep_d   = cfg_repeat;
                        ipg_d   = cfg_ipg;
                        pass_d  = '0;
                        stop_d  = 1'b0;
                        pkt_d   = '0;
                        flit_d  = '0;
                        ptr_d   = '0;
                        valid_d = 1'b1;
                        data_d  = mem_data[0];
                        keep_d  = mem_keep[0];
                        last_d  = mem_last[0];
                    end
                end
            end
            StSend: begin
                if (hs) begin
                    flit_d = flit_q + 32'd1;
                    if (last_q) begin
                        pkt_d = pkt_q + 32'd1;
                    end
                    ptr_d  = nxt_ptr;
                    data_d = mem_data[nxt_ptr];
                    keep_d = mem_keep[nxt_ptr];
                    last_d = mem_last[nxt_ptr];
                    if (end_pass) begin
                        pass_d = pass_inc;
                    end
                    if ((end_pass && rep_q != '0 && pass_inc >= rep_q) || (last_q && stop_any)) begin
                        state_d = StIdle;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else if (last_q && ipg_q != '0) begin
                        state_d = StGap;
                        gap_d   = ipg_q;
                        valid_d = 1'b0;
                    end
                end
            end
            StGap: begin
                if (stop_any) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (gap_q <= GAP_W'(1)) begin
                    state_d = StSend;
                    valid_d = 1'b1;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            num_q   <= '0;
            rep_q   <= '0;
            pass_q  <= '0;
            ipg_q   <= '0;
            gap_q   <= '0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            pkt_q   <= '0;
            flit_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            num_q   <= num_d;
            rep_q   <= rep_d;
            pass_q  <= pass_d;
            ipg_q   <= ipg_d;
            gap_q   <= gap_d;
            stop_q  <= stop_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            pkt_q   <= pkt_d;
            flit_q  <= flit_d;
        end
    end
endmodule

// File: tb/tb_axis_pkt_replay_engine.sv
// Scoreboard bench for axis_pkt_replay_engine: expected flits are queued at start and
// popped on every observed handshake; gaps, stalls and done pulses are watched alongside.
module tb_axis_pkt_replay_engine;
    localparam int unsigned DW    = 32;
    localparam int unsigned KW    = DW / 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned FW    = 1 + KW + DW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_en = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [DW-1:0]   wr_tdata = '0;
    logic [KW-1:0]   wr_tkeep = '0;
    logic            wr_tlast = 1'b0;
    logic [AW:0]     cfg_num_flits = '0;
    logic [15:0]     cfg_repeat = '0;
    logic [15:0]     cfg_ipg = '0;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic            busy, done;
    logic [31:0]     pkt_cnt, flit_cnt;
    logic [DW-1:0]   m_axis_tdata;
    logic [KW-1:0]   m_axis_tkeep;
    logic            m_axis_tlast, m_axis_tvalid;
    logic            m_axis_tready;

    int              checks = 0;
    int              errors = 0;
    logic [FW-1:0]   model [DEPTH];
    logic [FW-1:0]   exp_q [$];
    int              ready_mode = 0;
    int              rdy_ph = 0;
    int              done_cnt = 0;
    int              exp_ipg = 0;
    int              idle_cnt = 0;
    bit              gap_pending = 0;
    bit              stall_pend = 0;
    logic [FW-1:0]   stall_flit;
    logic [FW-1:0]   mon_flit;

    assign mon_flit = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};

    axis_pkt_replay_engine #(
        .TDATA_WIDTH (DW),
        .DEPTH       (DEPTH),
        .GAP_W       (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_tdata      (wr_tdata),
        .wr_tkeep      (wr_tkeep),
        .wr_tlast      (wr_tlast),
        .cfg_num_flits (cfg_num_flits),
        .cfg_repeat    (cfg_repeat),
        .cfg_ipg       (cfg_ipg),
        .start         (start),
        .stop          (stop),
        .busy          (busy),
        .done          (done),
        .pkt_cnt       (pkt_cnt),
        .flit_cnt      (flit_cnt),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ready pattern 1: 1,0,0 repeating.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: m_axis_tready = 1'b1;
                1: begin
                    m_axis_tready = (rdy_ph == 0);
                    rdy_ph = (rdy_ph == 2) ? 0 : rdy_ph + 1;
                end
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    // Monitor: sampled mid-cycle, a valid&&ready seen here is the handshake at the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_pend = 0;
        end else begin
            if (done) begin
                done_cnt++;
                check("done_busy_low", busy, 1'b0);
            end
            if (stall_pend) begin
                check("stall_valid_held", m_axis_tvalid, 1'b1);
                check("stall_data_stable", mon_flit, stall_flit);
            end
            if (m_axis_tvalid) begin
                if (gap_pending) begin
                    check("gap_len", idle_cnt, exp_ipg);
                    gap_pending = 0;
                end
                if (m_axis_tready) begin
                    check("flit_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) check("flit", mon_flit, exp_q.pop_front());
                    if (m_axis_tlast) begin
                        gap_pending = 1;
                        idle_cnt = 0;
                    end
                end
                stall_pend = !m_axis_tready;
                stall_flit = mon_flit;
            end else begin
                stall_pend = 0;
                if (busy) idle_cnt++;
            end
        end
    end

    task automatic load_flit(input int addr, input logic last);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        d = $urandom;
        k = KW'($urandom_range(1, (1 << KW) - 1));
        @(posedge clk);
        #1;
        wr_en = 1'b1;
        wr_addr = AW'(addr);
        wr_tdata = d;
        wr_tkeep = k;
        wr_tlast = last;
        model[addr] = {last, k, d};
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic push_passes(input int num, input int passes);
        for (int p = 0; p < passes; p++)
            for (int i = 0; i < num; i++) exp_q.push_back(model[i]);
    endtask

    task automatic start_pulse(input int num, input int rep, input int ipg, input bit exp_busy);
        @(posedge clk);
        #1;
        gap_pending = 0;
        exp_ipg = ipg;
        cfg_num_flits = (AW + 1)'(num);
        cfg_repeat = 16'(rep);
        cfg_ipg = 16'(ipg);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_busy", busy, exp_busy);
        check("start_valid", m_axis_tvalid, exp_busy);
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) check("done_timeout", 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("done_once", done_cnt - d0, 1);
        check("idle_after_done", busy, 1'b0);
    endtask

    task automatic wait_flits(input int target);
        int n;
        n = 0;
        while (flit_cnt != 32'(target) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("flit_reach", flit_cnt, target);
    endtask

    task automatic run(input int num, input int rep, input int ipg, input int pk, input int fl);
        push_passes(num, rep);
        start_pulse(num, rep, ipg, 1'b1);
        wait_done(300);
        check("sb_drained", exp_q.size(), 0);
        check("pkt_cnt", pkt_cnt, pk);
        check("flit_cnt", flit_cnt, fl);
    endtask

    initial begin
        #12;
        check("rst_valid", m_axis_tvalid, 1'b0);
        check("rst_data", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cnts", {pkt_cnt, flit_cnt}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic replay.
        for (int i = 0; i < 3; i++) load_flit(i, i == 2);
        run(3, 1, 0, 1, 3);

        // Backpressure.
        ready_mode = 1;
        run(3, 1, 0, 1, 3);
        ready_mode = 0;

        // Gap and repeat: two 2-flit packets, ipg 4, three passes.
        for (int i = 0; i < 4; i++) load_flit(i, i[0]);
        run(4, 3, 4, 6, 12);

        // Loop then stop mid-packet: finishes at the end of the third packet.
        push_passes(4, 3);
        start_pulse(4, 0, 0, 1'b1);
        wait_flits(5);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        wait_done(100);
        check("stop_pkt_cnt", pkt_cnt, 3);
        check("stop_flit_cnt", flit_cnt, 6);
        exp_q.delete();

        // Stop during a gap ends immediately.
        push_passes(4, 2);
        start_pulse(4, 0, 6, 1'b1);
        wait_flits(2);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        check("gap_stop_done", done, 1'b1);
        wait_done(10);
        check("gap_stop_pkt", pkt_cnt, 1);
        check("gap_stop_flit", flit_cnt, 2);
        exp_q.delete();

        // Zero-length start.
        start_pulse(0, 1, 0, 1'b0);
        check("zero_done", done, 1'b1);
        @(posedge clk);
        #1;
        check("zero_done_clear", done, 1'b0);
        check("zero_busy", busy, 1'b0);

        // Write and start while busy are both ignored.
        for (int i = 0; i < 3; i++) load_flit(i, i == 2);
        ready_mode = 1;
        push_passes(3, 1);
        start_pulse(3, 1, 0, 1'b1);
        wait_flits(1);
        @(posedge clk);
        #1;
        wr_en = 1'b1;
        wr_addr = '0;
        wr_tdata = 32'hdead_beef;
        wr_tkeep = '1;
        wr_tlast = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        start = 1'b0;
        wait_done(100);
        check("busy_ign_flit_cnt", flit_cnt, 3);
        check("busy_ign_drained", exp_q.size(), 0);
        ready_mode = 0;
        run(3, 1, 0, 1, 3);

        // Asynchronous reset mid-stream, then replay from flit 0.
        push_passes(3, 4);
        start_pulse(3, 0, 0, 1'b1);
        wait_flits(4);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", m_axis_tvalid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_data", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, '0);
        check("arst_cnt", flit_cnt, 0);
        exp_q.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        run(3, 1, 0, 1, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
